// File: rtl/song_player.sv
// Square-wave song player: accepts one note code per beat, plays its tone for the
// articulated part of the beat, then a silent gap, with pause and synchronous reset.
module song_player #(
   parameter int unsigned BEAT_CYCLES = 12500000,
   parameter int unsigned GAP_CYCLES  = 625000
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic [3:0] note_in,
   input  logic       note_valid,
   output logic       note_ready,
   input  logic       enable,
   output logic       audio_out,
   output logic       playing,
   output logic [3:0] cur_note,
   output logic       note_done
);

   localparam int unsigned BeatBits = ($clog2(BEAT_CYCLES) > 24) ? $clog2(BEAT_CYCLES) : 24;
   localparam int unsigned ToneBits = 18;

   localparam logic [BeatBits-1:0] BeatLast = BeatBits'(BEAT_CYCLES - 1);
   localparam logic [BeatBits-1:0] PlayLast = BeatBits'(BEAT_CYCLES - GAP_CYCLES - 1);
   localparam bit                  HasGap   = (GAP_CYCLES != 0);

   typedef enum logic [1:0] {
      StIdle,
      StPlay,
      StGap
   } state_e;

   state_e                state_q, state_d;
   logic [BeatBits-1:0]   beat_q, beat_d;
   logic [ToneBits-1:0]   tone_q, tone_d;
   logic                  audio_q, audio_d;
   logic [3:0]            note_q, note_d;
   logic [ToneBits-1:0]   half_last;
   logic                  is_rest;
   logic                  tone_hit;

   // Half-period in clock cycles for each note code; REST has no tone.
   function automatic logic [ToneBits-1:0] half_period(input logic [3:0] code);
      logic [ToneBits-1:0] hp;
      case (code)
         4'd1:    hp = 18'd170265;
         4'd2:    hp = 18'd101239;
         4'd3:    hp = 18'd90194;
         4'd4:    hp = 18'd85132;
         4'd5:    hp = 18'd75844;
         4'd6:    hp = 18'd71586;
         4'd7:    hp = 18'd67569;
         4'd8:    hp = 18'd63776;
         4'd9:    hp = 18'd56818;
         4'd10:   hp = 18'd53630;
         4'd11:   hp = 18'd50620;
         4'd12:   hp = 18'd47778;
         4'd13:   hp = 18'd45096;
         4'd14:   hp = 18'd42566;
         4'd15:   hp = 18'd37921;
         default: hp = 18'd1;
      endcase
      return hp;
   endfunction

   assign half_last = half_period(note_q) - 18'd1;
   assign is_rest   = (note_q == 4'd0);
   assign tone_hit  = !is_rest && (tone_q == half_last);

   always_comb begin
      state_d    = state_q;
      beat_d     = beat_q;
      tone_d     = tone_q;
      audio_d    = audio_q;
      note_d     = note_q;
      note_ready = 1'b0;
      note_done  = 1'b0;

      if (!enable) begin
         // Everything holds; the tone restarts low when play resumes.
         audio_d = 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               note_ready = 1'b1;
               if (note_valid) begin
                  note_d  = note_in;
                  state_d = StPlay;
                  beat_d  = '0;
                  tone_d  = '0;
                  audio_d = 1'b0;
               end
            end

            StPlay: begin
               beat_d = beat_q + 1'b1;
               if (tone_hit) begin
                  tone_d  = '0;
                  audio_d = ~audio_q;
               end else if (!is_rest) begin
                  tone_d = tone_q + 1'b1;
               end
               // Without a gap PlayLast equals BeatLast, so the beat ends here.
               if (beat_q == BeatLast) begin
                  note_done = 1'b1;
                  state_d   = StIdle;
                  beat_d    = '0;
                  tone_d    = '0;
                  audio_d   = 1'b0;
               end else if (HasGap && (beat_q == PlayLast)) begin
                  state_d = StGap;
                  tone_d  = '0;
                  audio_d = 1'b0;
               end
            end

            StGap: begin
               beat_d  = beat_q + 1'b1;
               audio_d = 1'b0;
               if (beat_q == BeatLast) begin
                  note_done = 1'b1;
                  state_d   = StIdle;
                  beat_d    = '0;
               end
            end

            default: begin
               state_d = StIdle;
               beat_d  = '0;
               tone_d  = '0;
               audio_d = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q <= StIdle;
         beat_q  <= '0;
         tone_q  <= '0;
         audio_q <= 1'b0;
         note_q  <= 4'd0;
      end else begin
         state_q <= state_d;
         beat_q  <= beat_d;
         tone_q  <= tone_d;
         audio_q <= audio_d;
         note_q  <= note_d;
      end
   end

   assign audio_out = audio_q && enable && (state_q == StPlay);
   assign playing   = (state_q != StIdle);
   assign cur_note  = note_q;

endmodule

// File: tb/tb_song_player.sv
// Directed bench for song_player: three instances with short beats cover reset,
// REST, pause, mid-note reset, busy rejection, back-to-back notes and A2 tone timing.
module tb_song_player;

   logic clock   = 1'b0;
   logic reset_n = 1'b0;
   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;

   // g_: BEAT 40, GAP 8
   logic [3:0] g_note_in = 4'd0;
   logic       g_valid = 1'b0, g_enable = 1'b1;
   logic       g_ready, g_audio, g_playing, g_done;
   logic [3:0] g_cur;
   // z_: BEAT 40, GAP 0
   logic [3:0] z_note_in = 4'd0;
   logic       z_valid = 1'b0, z_enable = 1'b1;
   logic       z_ready, z_audio, z_playing, z_done;
   logic [3:0] z_cur;
   // b_: BEAT 57000, GAP 100 (long enough for one A2 half-period)
   logic [3:0] b_note_in = 4'd0;
   logic       b_valid = 1'b0, b_enable = 1'b1;
   logic       b_ready, b_audio, b_playing, b_done;
   logic [3:0] b_cur;

   song_player #(.BEAT_CYCLES(40), .GAP_CYCLES(8)) u_gap (
      .clock(clock), .reset_n(reset_n), .note_in(g_note_in), .note_valid(g_valid),
      .note_ready(g_ready), .enable(g_enable), .audio_out(g_audio), .playing(g_playing),
      .cur_note(g_cur), .note_done(g_done)
   );

   song_player #(.BEAT_CYCLES(40), .GAP_CYCLES(0)) u_nogap (
      .clock(clock), .reset_n(reset_n), .note_in(z_note_in), .note_valid(z_valid),
      .note_ready(z_ready), .enable(z_enable), .audio_out(z_audio), .playing(z_playing),
      .cur_note(z_cur), .note_done(z_done)
   );

   song_player #(.BEAT_CYCLES(57000), .GAP_CYCLES(100)) u_big (
      .clock(clock), .reset_n(reset_n), .note_in(b_note_in), .note_valid(b_valid),
      .note_ready(b_ready), .enable(b_enable), .audio_out(b_audio), .playing(b_playing),
      .cur_note(b_cur), .note_done(b_done)
   );

   // Move to just after the next rising edge, where inputs are driven.
   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      step(); reset_n = 1'b0;
      step(); reset_n = 1'b1;
      @(negedge clock);
      checks++; if (g_playing !== 1'b0) begin errors++; $display("FAIL reset_playing got %b want 0", g_playing); end
      checks++; if (g_cur !== 4'd0) begin errors++; $display("FAIL reset_cur_note got %0d want 0", g_cur); end
      checks++; if (g_audio !== 1'b0 || g_done !== 1'b0) begin errors++; $display("FAIL reset_audio_done got %b%b want 00", g_audio, g_done); end
      checks++; if (g_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", g_ready); end
      step(); g_enable = 1'b0;
      @(negedge clock);
      checks++; if (g_ready !== 1'b0) begin errors++; $display("FAIL ready_paused got %b want 0", g_ready); end
      step(); g_enable = 1'b1;
      @(negedge clock);
      checks++; if (g_ready !== 1'b1) begin errors++; $display("FAIL ready_resumed got %b want 1", g_ready); end
   endtask

   task automatic test_rest();
      int high = 0, not_playing = 0, dones = 0, done_k = -1;
      step(); g_note_in = 4'd0; g_valid = 1'b1;
      @(negedge clock);
      checks++; if (g_ready !== 1'b1) begin errors++; $display("FAIL rest_accept_ready got %b want 1", g_ready); end
      for (int k = 1; k <= 41; k++) begin
         step(); g_valid = 1'b0;
         @(negedge clock);
         if (g_audio) high++;
         if (k <= 40 && !g_playing) not_playing++;
         if (g_done) begin dones++; done_k = k; end
      end
      checks++; if (high != 0) begin errors++; $display("FAIL rest_audio high cycles %0d want 0", high); end
      checks++; if (not_playing != 0) begin errors++; $display("FAIL rest_playing low cycles %0d want 0", not_playing); end
      checks++; if (dones != 1) begin errors++; $display("FAIL rest_done_count got %0d want 1", dones); end
      checks++; if (done_k != 40) begin errors++; $display("FAIL rest_done_cycle got %0d want 40", done_k); end
      checks++; if (g_playing !== 1'b0 || g_ready !== 1'b1) begin errors++; $display("FAIL rest_idle playing %b ready %b want 0 1", g_playing, g_ready); end
   endtask

   task automatic test_pause();
      int bad = 0, dones = 0, done_k = -1;
      logic [3:0] mid_note = 4'd0;
      step(); g_note_in = 4'd4; g_valid = 1'b1;
      for (int k = 1; k <= 60; k++) begin
         step(); g_valid = 1'b0; g_enable = !(k >= 5 && k < 15);
         @(negedge clock);
         if (k >= 5 && k < 15 && (g_audio || g_ready || !g_playing || g_done)) bad++;
         if (k == 10) mid_note = g_cur;
         if (g_done) begin dones++; if (done_k < 0) done_k = k; end
      end
      checks++; if (bad != 0) begin errors++; $display("FAIL pause_outputs bad cycles %0d want 0", bad); end
      checks++; if (mid_note !== 4'd4) begin errors++; $display("FAIL pause_cur_note got %0d want 4", mid_note); end
      checks++; if (done_k != 50) begin errors++; $display("FAIL pause_done_cycle got %0d want 50", done_k); end
      checks++; if (dones != 1) begin errors++; $display("FAIL pause_done_count got %0d want 1", dones); end
   endtask

   task automatic test_reset_mid_play();
      step(); g_note_in = 4'd14; g_valid = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         step(); g_valid = 1'b0; reset_n = (k != 5);
         @(negedge clock);
         if (k == 4) begin
            checks++; if (g_playing !== 1'b1 || g_cur !== 4'd14) begin errors++; $display("FAIL midreset_before playing %b cur %0d want 1 14", g_playing, g_cur); end
         end
      end
      checks++; if (g_playing !== 1'b0 || g_audio !== 1'b0) begin errors++; $display("FAIL midreset_state playing %b audio %b want 0 0", g_playing, g_audio); end
      checks++; if (g_cur !== 4'd0) begin errors++; $display("FAIL midreset_cur_note got %0d want 0", g_cur); end
      checks++; if (g_ready !== 1'b1 || g_done !== 1'b0) begin errors++; $display("FAIL midreset_ready ready %b done %b want 1 0", g_ready, g_done); end
   endtask

   task automatic test_valid_in_play();
      int acc_k = -1, ready_bad = 0, done_k = -1;
      logic [3:0] mid_note = 4'd0, new_note = 4'd0;
      step(); g_note_in = 4'd5; g_valid = 1'b1;
      for (int k = 1; k <= 43; k++) begin
         step(); g_valid = (k >= 3 && acc_k < 0); if (k >= 3) g_note_in = 4'd12;
         @(negedge clock);
         if (k >= 3 && k <= 40 && g_ready) ready_bad++;
         if (g_valid && g_ready && acc_k < 0) acc_k = k;
         if (g_done && done_k < 0) done_k = k;
         if (k == 20) mid_note = g_cur;
         if (k == 42) new_note = g_cur;
      end
      g_valid = 1'b0;
      checks++; if (ready_bad != 0) begin errors++; $display("FAIL busy_ready high cycles %0d want 0", ready_bad); end
      checks++; if (mid_note !== 4'd5) begin errors++; $display("FAIL busy_cur_note got %0d want 5", mid_note); end
      checks++; if (done_k != 40) begin errors++; $display("FAIL busy_done_cycle got %0d want 40", done_k); end
      checks++; if (acc_k != 41) begin errors++; $display("FAIL busy_accept_cycle got %0d want 41", acc_k); end
      checks++; if (new_note !== 4'd12) begin errors++; $display("FAIL busy_new_note got %0d want 12", new_note); end
      repeat (45) step();
   endtask

   task automatic test_back_to_back();
      int acc[2] = '{-1, -1};
      int n_acc = 0, done_k = -1, idle_in_beat = 0;
      logic [3:0] second = 4'd0;
      for (int k = 0; k <= 85; k++) begin
         step(); z_valid = (n_acc < 2); z_note_in = (n_acc >= 1) ? 4'd14 : 4'd4;
         @(negedge clock);
         if (z_valid && z_ready) begin acc[n_acc] = k; n_acc++; end
         if (z_done && done_k < 0) done_k = k;
         if (k >= 1 && k <= 40 && !z_playing) idle_in_beat++;
         if (k == 42) second = z_cur;
      end
      z_valid = 1'b0;
      checks++; if (acc[0] != 0) begin errors++; $display("FAIL b2b_first_accept got %0d want 0", acc[0]); end
      checks++; if (acc[1] - acc[0] != 41) begin errors++; $display("FAIL b2b_pitch got %0d want 41", acc[1] - acc[0]); end
      checks++; if (done_k != 40) begin errors++; $display("FAIL b2b_done_cycle got %0d want 40", done_k); end
      checks++; if (idle_in_beat != 0) begin errors++; $display("FAIL b2b_playing low cycles %0d want 0", idle_in_beat); end
      checks++; if (second !== 4'd14) begin errors++; $display("FAIL b2b_second_note got %0d want 14", second); end
      checks++; if (z_playing !== 1'b0) begin errors++; $display("FAIL b2b_final_idle playing %b want 0", z_playing); end
   endtask

   task automatic test_tone();
      int high = 0, first_hi = -1, last_hi = -1, done_k = -1;
      step(); b_note_in = 4'd9; b_valid = 1'b1;
      @(negedge clock);
      checks++; if (b_ready !== 1'b1) begin errors++; $display("FAIL tone_accept_ready got %b want 1", b_ready); end
      for (int k = 1; k <= 57002; k++) begin
         step(); b_valid = 1'b0;
         @(negedge clock);
         if (b_audio) begin high++; if (first_hi < 0) first_hi = k; last_hi = k; end
         if (b_done && done_k < 0) done_k = k;
      end
      checks++; if (first_hi != 56819) begin errors++; $display("FAIL tone_rise got %0d want 56819", first_hi); end
      checks++; if (last_hi != 56900) begin errors++; $display("FAIL tone_gap_cut got %0d want 56900", last_hi); end
      checks++; if (high != 82) begin errors++; $display("FAIL tone_high_cycles got %0d want 82", high); end
      checks++; if (done_k != 57000) begin errors++; $display("FAIL tone_done_cycle got %0d want 57000", done_k); end
      checks++; if (b_playing !== 1'b0 || b_cur !== 4'd9) begin errors++; $display("FAIL tone_idle playing %b cur %0d want 0 9", b_playing, b_cur); end
   endtask

   initial begin
      test_reset();
      test_rest();
      test_pause();
      test_reset_mid_play();
      test_valid_in_play();
      test_back_to_back();
      test_tone();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
